// File: rtl/dff_sr_bank_pkg.sv
// Shared definitions for the set/reset flip-flop bank: both-low mode
// constants and the change-counter saturation helper.
package dff_sr_bank_pkg;

  // Action taken by a bit when SET_B and RESET_B are both asserted (low).
  typedef enum int unsigned {
    MODE_LOAD   = 32'd0,
    MODE_TOGGLE = 32'd1,
    MODE_HOLD   = 32'd2
  } mode_e;

  // Parameter limits, checked at elaboration by the top level.
  localparam int unsigned NCH_MIN   = 32'd1;
  localparam int unsigned NCH_MAX   = 32'd32;
  localparam int unsigned WIDTH_MIN = 32'd1;
  localparam int unsigned WIDTH_MAX = 32'd64;
  localparam int unsigned CNT_W_MIN = 32'd2;
  localparam int unsigned CNT_W_MAX = 32'd16;

  // Largest value a cnt_w-bit counter can hold; the counter sticks here.
  function automatic int unsigned cnt_sat_value(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/dff_sr_chan.sv
// One channel of the bank: WIDTH set/reset flip-flops sharing an enable,
// plus a registered change flag and a saturating change counter.
module dff_sr_chan
  import dff_sr_bank_pkg::*;
#(
  parameter int unsigned WIDTH         = 32'd8,
  parameter int unsigned CNT_W         = 32'd8,
  parameter int unsigned BOTH_LOW_MODE = MODE_LOAD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] set_b_i,
  input  logic [WIDTH-1:0] reset_b_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             chg_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next Q: evaluated bit by bit so an unknown D only reaches loaded bits.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        case ({set_b_i[b], reset_b_i[b]})
          2'b01:   q_d[b] = 1'b1;
          2'b10:   q_d[b] = 1'b0;
          2'b11:   q_d[b] = q_q[b];
          2'b00: begin
            case (BOTH_LOW_MODE)
              MODE_LOAD:   q_d[b] = d_i[b];
              MODE_TOGGLE: q_d[b] = ~q_q[b];
              MODE_HOLD:   q_d[b] = q_q[b];
              default:     q_d[b] = q_q[b];
            endcase
          end
          default: q_d[b] = q_q[b];
        endcase
      end
    end else begin
      q_d = q_q;
    end
  end

  // Change flag and counter: clear wins over increment, count sticks at max.
  always_comb begin
    chg_d = (q_d != q_q);
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (chg_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset overrides every other input and is not a change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= '0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o   = q_q;
  assign chg_o = chg_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/dff_sr_bank.sv
// Bank of NCH independent set/reset flip-flop channels with per-channel
// enable, change flag and saturating change counter.
module dff_sr_bank
  import dff_sr_bank_pkg::*;
#(
  parameter int unsigned NCH           = 32'd4,
  parameter int unsigned WIDTH         = 32'd8,
  parameter int unsigned CNT_W         = 32'd8,
  parameter int unsigned BOTH_LOW_MODE = MODE_LOAD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       EN,
  input  logic [NCH*WIDTH-1:0] D,
  input  logic [NCH*WIDTH-1:0] SET_B,
  input  logic [NCH*WIDTH-1:0] RESET_B,
  input  logic [NCH-1:0]       CNT_CLR,
  output logic [NCH*WIDTH-1:0] Q,
  output logic [NCH*WIDTH-1:0] Q_N,
  output logic [NCH-1:0]       CHG,
  output logic [NCH*CNT_W-1:0] CNT
);

  // Reject unsupported configurations before any hardware is built.
  if ((NCH < NCH_MIN) || (NCH > NCH_MAX)) begin : g_bad_nch
    $error("dff_sr_bank: NCH out of range 1..32");
  end
  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("dff_sr_bank: WIDTH out of range 1..64");
  end
  if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("dff_sr_bank: CNT_W out of range 2..16");
  end
  if ((BOTH_LOW_MODE != MODE_LOAD) && (BOTH_LOW_MODE != MODE_TOGGLE) &&
      (BOTH_LOW_MODE != MODE_HOLD)) begin : g_bad_mode
    $error("dff_sr_bank: illegal BOTH_LOW_MODE");
  end

  for (genvar c = 0; c < int'(NCH); c++) begin : g_chan
    dff_sr_chan #(
      .WIDTH        (WIDTH),
      .CNT_W        (CNT_W),
      .BOTH_LOW_MODE(BOTH_LOW_MODE)
    ) u_chan (
      .clk_i    (CLK),
      .rst_i    (RST),
      .en_i     (EN[c]),
      .d_i      (D[c*WIDTH +: WIDTH]),
      .set_b_i  (SET_B[c*WIDTH +: WIDTH]),
      .reset_b_i(RESET_B[c*WIDTH +: WIDTH]),
      .cnt_clr_i(CNT_CLR[c]),
      .q_o      (Q[c*WIDTH +: WIDTH]),
      .chg_o    (CHG[c]),
      .cnt_o    (CNT[c*CNT_W +: CNT_W])
    );
  end

  // Complement output follows Q combinationally, reset included.
  assign Q_N = ~Q;

endmodule

// File: tb/tb_dff_sr_bank.sv
// Self-checking bench: three bank configurations (load/8-bit counters,
// toggle/2-bit counters, hold/4-bit counters) driven by shared inputs.
module tb_dff_sr_bank;
  import dff_sr_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en, cnt_clr;
  logic [31:0] d, set_b, reset_b;

  logic [31:0] q_a [3];
  logic [31:0] qn_a [3];
  logic [3:0]  chg_a [3];
  logic [31:0] cnt_act [3];
  logic [31:0] cnt0;
  logic [7:0]  cnt1;
  logic [15:0] cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  logic [31:0] mq [3];
  logic [3:0]  mchg [3];
  int          mcnt [3][4];
  int          cmax [3] = '{255, 3, 15};
  int          cw   [3] = '{8, 2, 4};
  int          mode [3] = '{0, 1, 2};

  always #5 clk = ~clk;

  assign cnt_act[0] = cnt0;
  assign cnt_act[1] = {24'd0, cnt1};
  assign cnt_act[2] = {16'd0, cnt2};

  dff_sr_bank #(.NCH(4), .WIDTH(8), .CNT_W(8), .BOTH_LOW_MODE(MODE_LOAD)) dut_load (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .SET_B(set_b), .RESET_B(reset_b),
    .CNT_CLR(cnt_clr), .Q(q_a[0]), .Q_N(qn_a[0]), .CHG(chg_a[0]), .CNT(cnt0));

  dff_sr_bank #(.NCH(4), .WIDTH(8), .CNT_W(2), .BOTH_LOW_MODE(MODE_TOGGLE)) dut_tog (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .SET_B(set_b), .RESET_B(reset_b),
    .CNT_CLR(cnt_clr), .Q(q_a[1]), .Q_N(qn_a[1]), .CHG(chg_a[1]), .CNT(cnt1));

  dff_sr_bank #(.NCH(4), .WIDTH(8), .CNT_W(4), .BOTH_LOW_MODE(MODE_HOLD)) dut_hold (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .SET_B(set_b), .RESET_B(reset_b),
    .CNT_CLR(cnt_clr), .Q(q_a[2]), .Q_N(qn_a[2]), .CHG(chg_a[2]), .CNT(cnt2));

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [31:0] d;
    logic [31:0] set_b;
    logic [31:0] reset_b;
    logic [3:0]  cnt_clr;
    logic [31:0] eq;
    logic [3:0]  echg;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply the rules of the device to the model, using the current inputs.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k] = 32'd0;
        mchg[k] = 4'd0;
        for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] old_v, new_v;
          old_v = mq[k][c*8 +: 8];
          new_v = old_v;
          if (en[c]) begin
            for (int b = 0; b < 8; b++) begin
              logic s, r;
              s = set_b[c*8+b];
              r = reset_b[c*8+b];
              if (!s && r)      new_v[b] = 1'b1;
              else if (s && !r) new_v[b] = 1'b0;
              else if (s && r)  new_v[b] = old_v[b];
              else if (mode[k] == 0) new_v[b] = d[c*8+b];
              else if (mode[k] == 1) new_v[b] = ~old_v[b];
              else new_v[b] = old_v[b];
            end
          end
          mchg[k][c] = (new_v != old_v);
          if (cnt_clr[c]) mcnt[k][c] = 0;
          else if (mchg[k][c] && mcnt[k][c] < cmax[k]) mcnt[k][c]++;
          mq[k][c*8 +: 8] = new_v;
        end
      end
    end
  endtask

  // One clock edge: advance model, sample DUTs after the edge, compare.
  task automatic tick();
    logic [31:0] ec;
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      ec = 32'd0;
      for (int c = 0; c < 4; c++) ec = ec | (32'(mcnt[k][c]) << (c * cw[k]));
      check($sformatf("model_q%0d", k), q_a[k], mq[k]);
      check($sformatf("model_qn%0d", k), qn_a[k], ~mq[k]);
      check($sformatf("model_chg%0d", k), {28'd0, chg_a[k]}, {28'd0, mchg[k]});
      check($sformatf("model_cnt%0d", k), cnt_act[k], ec);
    end
  endtask

  task automatic set_in(input logic r, input logic [3:0] e, input logic [31:0] dd,
                        input logic [31:0] s, input logic [31:0] rb, input logic [3:0] cc);
    rst = r; en = e; d = dd; set_b = s; reset_b = rb; cnt_clr = cc;
  endtask

  initial begin
    // rst, en, d, set_b, reset_b, cnt_clr, exp Q, exp CHG, exp CNT (load instance)
    tbl[0] = '{1'b1, 4'hF, 32'h0, 32'h0,        32'hFFFFFFFF, 4'h0, 32'h00000000, 4'h0, 32'h00000000};
    tbl[1] = '{1'b0, 4'h1, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF, 4'h0, 32'h000000FF, 4'h1, 32'h00000001};
    tbl[2] = '{1'b0, 4'h2, 32'h0000A500, 32'hFFFF00FF, 32'hFFFF00FF, 4'h0, 32'h0000A5FF, 4'h2, 32'h00000101};
    tbl[3] = '{1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 32'h0000A5FF, 4'h0, 32'h00000101};
    tbl[4] = '{1'b0, 4'h7, 32'h0, 32'h00FFFFFF, 32'hFFFFFFFF, 4'h0, 32'h0000A5FF, 4'h0, 32'h00000101};
    tbl[5] = '{1'b0, 4'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFF00, 4'h0, 32'h0000A500, 4'h1, 32'h00000102};
    tbl[6] = '{1'b0, 4'h1, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF, 4'h1, 32'h0000A5FF, 4'h1, 32'h00000100};
    tbl[7] = '{1'b0, 4'h0, 32'h0, 32'h0,        32'h0,        4'h2, 32'h0000A5FF, 4'h0, 32'h00000000};
    tbl[8] = '{1'b1, 4'hF, 32'h0, 32'h0,        32'hFFFFFFFF, 4'hF, 32'h00000000, 4'h0, 32'h00000000};
    tbl[9] = '{1'b0, 4'hF, 32'h0, 32'h0,        32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 4'hF, 32'h01010101};

    for (int k = 0; k < 3; k++) begin
      mq[k] = 32'd0;
      mchg[k] = 4'd0;
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
    end
    set_in(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
    @(posedge clk);
    #1;

    // Directed table on the load-mode instance
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].d, tbl[i].set_b, tbl[i].reset_b, tbl[i].cnt_clr);
      tick();
      check($sformatf("tbl%0d_q", i), q_a[0], tbl[i].eq);
      check($sformatf("tbl%0d_qn", i), qn_a[0], ~tbl[i].eq);
      check($sformatf("tbl%0d_chg", i), {28'd0, chg_a[0]}, {28'd0, tbl[i].echg});
      check($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].ecnt);
    end

    // Toggle mode, ch2 both low for three edges from zero
    set_in(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
    tick();
    set_in(1'b0, 4'h4, 32'h0, 32'hFF00FFFF, 32'hFF00FFFF, 4'h0);
    tick();
    check("tog_ch2_q1", {24'd0, q_a[1][23:16]}, 32'h000000FF);
    tick();
    check("tog_ch2_q2", {24'd0, q_a[1][23:16]}, 32'h00000000);
    tick();
    check("tog_ch2_q3", {24'd0, q_a[1][23:16]}, 32'h000000FF);
    check("tog_ch2_cnt", {30'd0, cnt1[5:4]}, 32'd3);
    check("tog_other_q", {8'd0, q_a[1][31:24], q_a[1][15:0]}, 32'd0);

    // 2-bit counter saturation, then clear beats increment
    set_in(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
    tick();
    set_in(1'b0, 4'h1, 32'h0, 32'hFFFFFF00, 32'hFFFFFF00, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), {30'd0, cnt1[1:0]}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    cnt_clr = 4'h1;
    tick();
    check("clr_cnt", {30'd0, cnt1[1:0]}, 32'd0);
    check("clr_chg", {31'd0, chg_a[1][0]}, 32'd1);

    // Reset while every channel toggles
    set_in(1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_q", q_a[1], 32'h0);
    check("rst_qn", qn_a[1], 32'hFFFFFFFF);
    check("rst_chg", {28'd0, chg_a[1]}, 32'd0);
    check("rst_cnt", {24'd0, cnt1}, 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      en      = 4'($urandom);
      d       = $urandom;
      set_b   = $urandom | ($urandom & $urandom);
      reset_b = $urandom | ($urandom & $urandom);
      cnt_clr = 4'($urandom & $urandom & $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_sr_bank.md
DFF_SR_BANK -- requirements
Module: dff_sr_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent channels, range 1..32.
REQ-002 Parameter WIDTH, default 8: bits per channel, range 1..64.
REQ-003 Parameter CNT_W, default 8: width of each per-channel change counter, range 2..16.
REQ-004 Parameter BOTH_LOW_MODE, default MODE_LOAD: action of a bit when SET_B and RESET_B are both low; one of MODE_LOAD, MODE_TOGGLE, MODE_HOLD.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 EN  input  NCH  per-channel update enable; bit c gates channel c.
REQ-008 D  input  NCH*WIDTH  data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 SET_B  input  NCH*WIDTH  per-bit set, active-low; same packing as D.
REQ-010 RESET_B  input  NCH*WIDTH  per-bit clear, active-low; same packing as D.
REQ-011 CNT_CLR  input  NCH  per-channel synchronous clear of the change counter.
REQ-012 Q  output  NCH*WIDTH  registered state.
REQ-013 Q_N  output  NCH*WIDTH  bitwise complement of Q.
REQ-014 CHG  output  NCH  registered flag: channel Q changed on the most recent edge.
REQ-015 CNT  output  NCH*CNT_W  per-channel saturating count of edges on which the channel Q changed.

Function
REQ-016 Q_N SHALL equal ~Q combinationally at all times, including during reset.
REQ-017 Each Q bit SHALL update with 1-cycle latency from the SET_B, RESET_B, D and EN values sampled at the rising edge.
REQ-018 With EN[c]=1, per bit: SET_B=0 and RESET_B=1 -> 1; SET_B=1 and RESET_B=0 -> 0; both high -> hold.
REQ-019 With EN[c]=1 and SET_B=0 and RESET_B=0: MODE_LOAD -> D bit; MODE_TOGGLE -> ~Q bit; MODE_HOLD -> hold.
REQ-020 With EN[c]=0, every Q bit of channel c SHALL hold, regardless of SET_B, RESET_B and D.
REQ-021 CHG[c] SHALL be 1 on the cycle after an edge where next Q of channel c differs from current Q of channel c in any bit; otherwise CHG[c] SHALL be 0.
REQ-022 CNT[c] SHALL increment by 1 on each edge where channel c changes, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-023 CNT_CLR[c]=1 SHALL force CNT[c] to 0 on that edge, with priority over a simultaneous increment.
REQ-024 CNT_CLR SHALL NOT affect Q or CHG.
REQ-025 Channels SHALL be fully independent; no input of channel c SHALL affect the outputs of any other channel.
REQ-026 X on D in MODE_LOAD SHALL propagate to Q only for the bits selected for load.

Reset
REQ-027 RST=1 at an edge SHALL force Q=0, CHG=0 and CNT=0 for all channels.
REQ-028 RST SHALL take priority over EN, SET_B, RESET_B, D and CNT_CLR.
REQ-029 A reset-driven change of Q SHALL NOT set CHG or increment CNT.
REQ-030 RST asserted mid-operation SHALL take effect on the very next edge.
REQ-031 The first non-reset edge after RST deasserts SHALL behave per REQ-017..REQ-023.

Structure
REQ-032 Package dff_sr_bank_pkg SHALL hold the mode enumeration constants MODE_LOAD=0, MODE_TOGGLE=1 and MODE_HOLD=2.
REQ-033 Package dff_sr_bank_pkg SHALL hold a helper function that computes the counter saturation value.
REQ-034 One sub-module, dff_sr_chan, SHALL implement a single channel (Q, CHG, CNT); the top SHALL instantiate it NCH times in a generate loop.
REQ-035 An illegal BOTH_LOW_MODE or an out-of-range parameter SHALL be an elaboration-time error.

Verification
REQ-036 Reset, then ch0 SET_B=8'h00, RESET_B=8'hFF, EN=1 -> next cycle Q[ch0]=8'hFF, Q_N[ch0]=8'h00, CHG[0]=1, CNT[0]=1; other channels stay 0.
REQ-037 MODE_LOAD, ch1 SET_B=RESET_B=8'h00, D=8'hA5 -> Q[ch1]=8'hA5; next cycle both high -> Q[ch1] holds 8'hA5, CHG[1]=0.
REQ-038 MODE_TOGGLE, ch2 both low for 3 edges from Q=0 -> Q[ch2] goes 8'hFF, 8'h00, 8'hFF and CNT[2]=3.
REQ-039 EN[3]=0 with SET_B=0 for 5 cycles -> Q[ch3] stays 0, CHG[3]=0, CNT[3]=0.
REQ-040 CNT_W=2, toggle ch0 5 times -> CNT[0] reads 1, 2, 3, 3, 3; CNT_CLR plus change on the same edge -> CNT[0]=0.
REQ-041 RST pulsed while all channels toggle -> next cycle Q=0, CHG=0, CNT=0, Q_N all ones.
